instr_decoder: RTL and testbench
================================

# instr_decoder

SPI instruction decoder for the PWM signal generator peripheral. It sits between the SPI byte bridge and the register bank. It parses a two-byte frame (command byte, then data byte) and drives the register bank's `read`/`write`/`addr`/`data_write` strobes. For reads it captures `data_read` into the byte the bridge shifts out on MISO during the second byte.

## Interface
Parameters: none. Widths are fixed by the register map.

- `clk`  in  1  peripheral clock; all logic is synchronous to its rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `cs_active`  in  1  level from the bridge; 1 while chip-select is asserted
- `byte_sync`  in  1  one-cycle pulse: `data_in` holds a complete received byte
- `data_in`  in  8  received byte; valid only when `byte_sync` is high
- `data_out`  out  8  byte for the bridge to shift out on the next byte slot; registered
- `read`  out  1  read strobe to the register bank
- `write`  out  1  write strobe to the register bank
- `addr`  out  6  register address: `{HL, index[4:0]}`
- `data_read`  in  8  combinational readback from the register bank
- `data_write`  out  8  write data to the register bank

## Operation
- Command byte format:
  - bit7 = W/nR (1 = write)
  - bit6 = HL (high-byte select)
  - bit5 = reserved, ignored
  - bits4:0 = register index
- `addr` <= `{cmd[6], cmd[4:0]}`.
- States:
  - S_CMD: waiting for a command byte.
  - S_RD_FETCH: one cycle.
  - S_DATA: waiting for the second byte.
- Transitions:
  - S_CMD, `byte_sync`: latch `addr` and a W/nR flag. Go to S_DATA if write, S_RD_FETCH if read.
  - S_RD_FETCH: `read`=1 for exactly this cycle. At the end of the cycle, `data_out` <= `data_read`. Go to S_DATA.
  - S_DATA, `byte_sync`, write frame: `data_write` <= `data_in`, `write` <= 1 (pulse next cycle). Go to S_CMD.
  - S_DATA, `byte_sync`, read frame: the received byte is a dummy and is discarded. Go to S_CMD.
- On entering S_DATA for a write frame, `data_out` <= 0x00.
- `data_out` otherwise holds its value until the next load.
- `cs_active`=0 in any state: return to S_CMD next cycle. No `write` is issued for a partial frame. `addr`, `data_write` and `data_out` keep their values.
- `cs_active`=0 has priority over a coincident `byte_sync`; that byte is dropped.
- `byte_sync` arriving during S_RD_FETCH: the fetch still completes, the byte is taken as the dummy data byte, and the next state is S_CMD.
- Reserved/unmapped indices are forwarded unchanged; the register bank decides the readback (0xFF) and ignores the write.
- Reset values: state S_CMD, `read`=0, `write`=0, `addr`=0x00, `data_write`=0x00, `data_out`=0x00.

## Timing
- `byte_sync` of a read command in cycle T:
  - `addr` valid from T+1.
  - `read`=1 in T+1 only.
  - `data_out` valid from T+2.
- The bridge guarantees at least 8 clk between `byte_sync` pulses, so `data_out` is settled long before the second byte slot.
- `byte_sync` of a write data byte in cycle T2: `write`=1 and `data_write` valid in T2+1 only. The register bank samples at the end of T2+1.
- `addr` stays stable from the command byte until the next command byte. It is therefore valid throughout every `read` and `write` strobe.
- `read` and `write` are never high in the same cycle.
- Each strobe is at most one cycle wide; there are no back-to-back strobes from a single frame.
- Reset asserted mid-frame clears everything asynchronously. The first `byte_sync` after release is treated as a command byte.

## Structure
- Shared package `pwm_pkg`:
  - state enum `{S_CMD, S_RD_FETCH, S_DATA}`
  - command-byte bit positions `CMD_WR_BIT`=7, `CMD_HL_BIT`=6
  - `ADDR_W`=6, `DATA_W`=8
- Single flat module; no sub-module is warranted.
- One registered state machine plus output registers.

## Test plan
- Write PERIOD low byte: frame 0x80, 0x34 -> single `write` pulse with `addr`=0x00, `data_write`=0x34, one cycle after the second `byte_sync`; no `read`.
- Read COMPARE1 high byte: frame 0x43, dummy 0x00, with the model returning 0xAB -> `read` pulse with `addr`=0x23 one cycle after the first `byte_sync`; `data_out`=0xAB one cycle later; no `write`.
- Write 0x80 then drop `cs_active` before the second byte -> no `write`. A following frame 0x8A, 0x05 gives `write` with `addr`=0x0A, `data_write`=0x05.
- Reserved bit set: frame 0xA2, 0x01 -> `addr`=0x02 (bit5 ignored), `write` with `data_write`=0x01.
- `rst_n` pulsed low between the command byte 0x8C and the data byte -> no `write`, all outputs 0. The next byte 0x0D is treated as a read command: `read` with `addr`=0x0D.
- Back-to-back frames with minimum spacing (write 0x8B, 0x00 then read 0x0B) -> exactly one `write` then one `read`, never overlapping.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM signal generator peripheral.
// Provides the SPI instruction decoder state encoding, command-byte bit
// positions and the register-map bus widths.
package pwm_pkg;

  typedef enum logic [1:0] {
    S_CMD,
    S_RD_FETCH,
    S_DATA
  } state_t;

  localparam int unsigned CMD_WR_BIT = 7;
  localparam int unsigned CMD_HL_BIT = 6;
  localparam int unsigned ADDR_W     = 6;
  localparam int unsigned DATA_W     = 8;

endpackage

// File: rtl/instr_decoder.sv
// SPI instruction decoder for the PWM signal generator peripheral.
// Parses a two-byte frame (command, data) from the SPI byte bridge and drives
// the register bank strobes. Read frames fetch the register one cycle after
// the command byte so data_out is ready for the second byte slot on MISO.
//
// Ports:
//   clk        in   peripheral clock (rising edge)
//   rst_n      in   asynchronous active-low reset
//   cs_active  in   1 while chip-select is asserted; 0 aborts the frame
//   byte_sync  in   one-cycle pulse, data_in holds a received byte
//   data_in    in   received byte
//   data_out   out  byte shifted out on the next byte slot (registered)
//   read       out  one-cycle read strobe to the register bank
//   write      out  one-cycle write strobe to the register bank
//   addr       out  register address {HL, index[4:0]}
//   data_read  in   combinational readback from the register bank
//   data_write out  write data to the register bank
module instr_decoder
  import pwm_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_active,
  input  logic              byte_sync,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              read,
  output logic              write,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_read,
  output logic [DATA_W-1:0] data_write
);

  state_t              r_state;
  logic                r_wr;
  logic                r_read;
  logic                r_write;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data_write;
  logic [DATA_W-1:0]   r_data_out;

  logic [ADDR_W-1:0]   w_cmd_addr;
  logic                w_unused_rsvd;

  // Bit 5 of the command byte is reserved and deliberately dropped.
  assign w_cmd_addr    = {data_in[CMD_HL_BIT], data_in[4:0]};
  assign w_unused_rsvd = data_in[5];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_CMD;
      r_wr         <= 1'b0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_data_write <= '0;
      r_data_out   <= '0;
    end else begin
      r_read  <= 1'b0;
      r_write <= 1'b0;
      if (!cs_active) begin
        // Frame abort wins over a coincident byte; address/data hold.
        r_state <= S_CMD;
      end else begin
        case (r_state)
          S_CMD: begin
            if (byte_sync) begin
              r_addr <= w_cmd_addr;
              r_wr   <= data_in[CMD_WR_BIT];
              if (data_in[CMD_WR_BIT]) begin
                r_data_out <= '0;
                r_state    <= S_DATA;
              end else begin
                // Strobe is registered, so it is high during S_RD_FETCH.
                r_read  <= 1'b1;
                r_state <= S_RD_FETCH;
              end
            end
          end
          S_RD_FETCH: begin
            r_data_out <= data_read;
            // An early byte is accepted as the dummy and closes the frame.
            r_state    <= byte_sync ? S_CMD : S_DATA;
          end
          S_DATA: begin
            if (byte_sync) begin
              if (r_wr) begin
                r_data_write <= data_in;
                r_write      <= 1'b1;
              end
              r_state <= S_CMD;
            end
          end
          default: r_state <= S_CMD;
        endcase
      end
    end
  end

  assign read       = r_read;
  assign write      = r_write;
  assign addr       = r_addr;
  assign data_write = r_data_write;
  assign data_out   = r_data_out;

endmodule

// File: tb/tb_instr_decoder.sv
module tb_instr_decoder;

  logic       clk;
  logic       rst_n;
  logic       cs_active;
  logic       byte_sync;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       read;
  logic       write;
  logic [5:0] addr;
  logic [7:0] data_read;
  logic [7:0] data_write;

  int checks = 0;
  int errors = 0;

  // Register bank model: fixed contents, reserved indices read 0xFF.
  logic [7:0] bank [64];
  assign data_read = bank[addr];

  // Byte-level reference model of the expected decoder outputs.
  int         m_pos;      // 0: next accepted byte is a command, 1: data byte
  bit         m_fetch;    // read command accepted last cycle, fetch pending
  bit         m_is_wr;
  logic       exp_read, exp_write;
  logic [5:0] exp_addr;
  logic [7:0] exp_dw, exp_dout;

  // Observed strobe statistics.
  int n_read = 0;
  int n_write = 0;

  instr_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cs_active  (cs_active),
    .byte_sync  (byte_sync),
    .data_in    (data_in),
    .data_out   (data_out),
    .read       (read),
    .write      (write),
    .addr       (addr),
    .data_read  (data_read),
    .data_write (data_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic reset_model();
    m_pos = 0; m_fetch = 0; m_is_wr = 0;
    exp_read = 0; exp_write = 0;
    exp_addr = '0; exp_dw = '0; exp_dout = '0;
  endtask

  // Drive one clock cycle of inputs, advance the model, sample #1 after the edge.
  task automatic tick(input logic cs, input logic bs, input logic [7:0] din);
    cs_active = cs; byte_sync = bs; data_in = din;
    exp_read = 0; exp_write = 0;
    if (!cs) begin
      m_pos = 0; m_fetch = 0;
    end else if (m_fetch) begin
      exp_dout = bank[exp_addr];
      m_fetch  = 0;
      m_pos    = bs ? 0 : 1;
    end else if (bs) begin
      if (m_pos == 0) begin
        exp_addr = {din[6], din[4:0]};
        m_is_wr  = din[7];
        m_pos    = 1;
        if (m_is_wr) exp_dout = 8'h00;
        else begin exp_read = 1; m_fetch = 1; end
      end else begin
        if (m_is_wr) begin exp_write = 1; exp_dw = din; end
        m_pos = 0;
      end
    end
    @(posedge clk); #1;
    byte_sync = 0;
    n_read  += int'(read);
    n_write += int'(write);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_reset();
    checks++; if (read !== 1'b0) begin errors++; $display("FAIL reset_read: got %b want 0", read); end
    checks++; if (write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b want 0", write); end
    checks++; if (addr !== 6'h00) begin errors++; $display("FAIL reset_addr: got %h want 00", addr); end
    checks++; if (data_write !== 8'h00) begin errors++; $display("FAIL reset_dw: got %h want 00", data_write); end
    checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", data_out); end
  endtask

  task automatic test_write_period();
    int w0 = n_write, r0 = n_read;
    tick(1, 1, 8'h80);
    checks++; if (addr !== 6'h00 || write !== 1'b0) begin errors++; $display("FAIL wp_cmd: addr %h write %b want 00 0", addr, write); end
    idle(7);
    tick(1, 1, 8'h34);
    checks++; if (write !== 1'b1) begin errors++; $display("FAIL wp_write: got %b want 1", write); end
    checks++; if (data_write !== 8'h34 || addr !== 6'h00) begin errors++; $display("FAIL wp_data: dw %h addr %h want 34 00", data_write, addr); end
    idle(3);
    checks++; if (n_write - w0 !== 1 || n_read - r0 !== 0) begin errors++; $display("FAIL wp_count: writes %0d reads %0d want 1 0", n_write - w0, n_read - r0); end
  endtask

  task automatic test_read_compare1();
    int w0 = n_write, r0 = n_read;
    tick(1, 1, 8'h43);
    checks++; if (read !== 1'b1 || addr !== 6'h23) begin errors++; $display("FAIL rd_strobe: read %b addr %h want 1 23", read, addr); end
    tick(1, 0, 8'h00);
    checks++; if (read !== 1'b0 || data_out !== 8'hAB) begin errors++; $display("FAIL rd_dout: read %b dout %h want 0 ab", read, data_out); end
    idle(6);
    tick(1, 1, 8'h00);
    idle(3);
    checks++; if (data_out !== 8'hAB) begin errors++; $display("FAIL rd_hold: got %h want ab", data_out); end
    checks++; if (n_write - w0 !== 0 || n_read - r0 !== 1) begin errors++; $display("FAIL rd_count: writes %0d reads %0d want 0 1", n_write - w0, n_read - r0); end
  endtask

  task automatic test_cs_abort();
    int w0 = n_write;
    tick(1, 1, 8'h80);
    idle(3);
    tick(0, 0, 8'h00);
    tick(0, 0, 8'h00);
    idle(4);
    checks++; if (n_write - w0 !== 0) begin errors++; $display("FAIL abort_nowrite: writes %0d want 0", n_write - w0); end
    tick(1, 1, 8'h8A);
    checks++; if (addr !== 6'h0A || data_out !== 8'h00) begin errors++; $display("FAIL abort_cmd: addr %h dout %h want 0a 00", addr, data_out); end
    idle(7);
    tick(1, 1, 8'h05);
    checks++; if (write !== 1'b1 || data_write !== 8'h05 || addr !== 6'h0A) begin errors++; $display("FAIL abort_write: write %b dw %h addr %h want 1 05 0a", write, data_write, addr); end
    idle(2);
    checks++; if (n_write - w0 !== 1) begin errors++; $display("FAIL abort_count: writes %0d want 1", n_write - w0); end
  endtask

  task automatic test_reserved_bit();
    tick(1, 1, 8'hA2);
    checks++; if (addr !== 6'h02) begin errors++; $display("FAIL rsvd_addr: got %h want 02", addr); end
    idle(7);
    tick(1, 1, 8'h01);
    checks++; if (write !== 1'b1 || data_write !== 8'h01) begin errors++; $display("FAIL rsvd_write: write %b dw %h want 1 01", write, data_write); end
    idle(2);
  endtask

  task automatic test_reset_midframe();
    int w0 = n_write, r0 = n_read;
    tick(1, 1, 8'h8C);
    idle(3);
    #2 rst_n = 0;
    #1;
    checks++; if ({read, write} !== 2'b00 || addr !== 6'h00 || data_write !== 8'h00 || data_out !== 8'h00) begin
      errors++; $display("FAIL rst_async: read %b write %b addr %h dw %h dout %h want all 0", read, write, addr, data_write, data_out);
    end
    @(posedge clk); #1;
    rst_n = 1;
    reset_model();
    idle(2);
    tick(1, 1, 8'h0D);
    checks++; if (read !== 1'b1 || write !== 1'b0 || addr !== 6'h0D) begin errors++; $display("FAIL rst_next_read: read %b write %b addr %h want 1 0 0d", read, write, addr); end
    idle(7);
    tick(1, 1, 8'h00);
    idle(2);
    checks++; if (n_write - w0 !== 0 || n_read - r0 !== 1) begin errors++; $display("FAIL rst_count: writes %0d reads %0d want 0 1", n_write - w0, n_read - r0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [4];
    seq[0] = 8'h8B; seq[1] = 8'h00; seq[2] = 8'h0B; seq[3] = 8'h00;
    for (int k = 0; k < 32; k++) begin
      tick(1, (k % 8) == 0, seq[k / 8]);
      checks++; if (write !== (k == 8)) begin errors++; $display("FAIL b2b_write k=%0d: got %b want %b", k, write, k == 8); end
      checks++; if (read !== (k == 16)) begin errors++; $display("FAIL b2b_read k=%0d: got %b want %b", k, read, k == 16); end
    end
  endtask

  task automatic test_byte_during_fetch();
    logic [7:0] want;
    want = bank[6'h05];
    tick(1, 1, 8'h05);
    tick(1, 1, 8'h77);
    checks++; if (data_out !== want) begin errors++; $display("FAIL fetch_dout: got %h want %h", data_out, want); end
    idle(8);
    tick(1, 1, 8'h81);
    idle(7);
    tick(1, 1, 8'h22);
    checks++; if (write !== 1'b1 || addr !== 6'h01 || data_write !== 8'h22) begin errors++; $display("FAIL fetch_next: write %b addr %h dw %h want 1 01 22", write, addr, data_write); end
    idle(2);
  endtask

  task automatic test_random();
    int   gap = 0;
    logic cs, bs;
    logic [7:0] din;
    for (int n = 0; n < 800; n++) begin
      cs  = ($urandom_range(0, 29) != 0);
      bs  = (gap == 0);
      din = 8'($urandom);
      if (bs) gap = $urandom_range(8, 11); else gap--;
      tick(cs, bs, din);
      checks++; if (read !== exp_read) begin errors++; $display("FAIL rnd_read n=%0d: got %b want %b", n, read, exp_read); end
      checks++; if (write !== exp_write) begin errors++; $display("FAIL rnd_write n=%0d: got %b want %b", n, write, exp_write); end
      checks++; if (addr !== exp_addr) begin errors++; $display("FAIL rnd_addr n=%0d: got %h want %h", n, addr, exp_addr); end
      checks++; if (data_write !== exp_dw) begin errors++; $display("FAIL rnd_dw n=%0d: got %h want %h", n, data_write, exp_dw); end
      checks++; if (data_out !== exp_dout) begin errors++; $display("FAIL rnd_dout n=%0d: got %h want %h", n, data_out, exp_dout); end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      logic [5:0] a;
      a = 6'(i);
      bank[i] = (a[4:0] >= 5'h18) ? 8'hFF : 8'($urandom);
    end
    bank[6'h23] = 8'hAB;
    rst_n = 0; cs_active = 0; byte_sync = 0; data_in = '0;
    reset_model();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1;
    idle(2);
    test_write_period();
    test_read_compare1();
    test_cs_abort();
    test_reserved_bit();
    test_reset_midframe();
    test_back_to_back();
    test_byte_during_fetch();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
